spi_xfer_ctrl: RTL and testbench

- SPI master transfer sequencer between the TX and RX sync FIFOs and the SPI pins.
- Pops a word from the TX FIFO, shifts it out MSB-first on mosi while shifting in miso, then pushes the received word into the RX FIFO.
- Keeps ss_n asserted across back-to-back frames. Programmable SCK divider; CPOL/CPHA modes 0-3.

---
 rtl/spi_xfer_ctrl_pkg.sv | 6 +
 rtl/spi_xfer_ctrl_sck_gen.sv | 31 +++
 rtl/spi_xfer_ctrl.sv | 141 ++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer sequencer.
package spi_xfer_ctrl_pkg;
  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, STORE, HOLD} spi_xfer_state_e;
endpackage

// File: rtl/spi_xfer_ctrl_sck_gen.sv
// SCK half-period timer and SCK level register.
module spi_sck_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 idle_en,
  input  logic                 idle_lvl,
  input  logic                 toggle,
  output logic                 tick,
  output logic                 sck
);
  logic [DIV_WIDTH-1:0] cnt;

  assign tick = (cnt == '0);

  // Reload on tick so each half-period is div+1 clk cycles long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load || tick) cnt <= div;
    else                   cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sck <= 1'b0;
    else if (idle_en) sck <= idle_lvl;
    else if (toggle)  sck <= ~sck;
  end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master frame sequencer between TX/RX FIFOs and the SPI pins.
// Optional SPI_XFER_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_empty,
  output logic                  tx_load,
  input  logic                  rx_full,
  output logic                  rx_store,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
`ifdef SPI_XFER_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  ss_n,
  output logic                  busy,
  output logic                  xfer_done
);
  localparam int EC_W = $clog2(2*DATA_WIDTH);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2*DATA_WIDTH-1);

  spi_xfer_state_e       state, state_nxt;
  logic                  start, take, tick;
  logic                  sck_load, sck_idle, sck_tgl;
  logic                  sample_bit, sample_now;
  logic                  cpha_q;
  logic [DIV_WIDTH-1:0]  div_q, div_sel;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic [EC_W-1:0]       edge_cnt;

  assign start = enable && !tx_empty && !rx_full;

`ifdef SPI_XFER_LOOPBACK_EN
  assign sample_bit = loopback ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  // Odd-numbered edges (edge_cnt even) are leading; CPHA=1 swaps sample and drive.
  assign sample_now = !edge_cnt[0] ^ cpha_q;

  spi_sck_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sck (
    .clk      (clk),
    .rst      (rst),
    .load     (sck_load),
    .div      (div_sel),
    .idle_en  (sck_idle),
    .idle_lvl (cpol),
    .toggle   (sck_tgl),
    .tick     (tick),
    .sck      (sck)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEAD;
      LEAD:    if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && edge_cnt == LAST_EDGE) state_nxt = TRAIL;
      TRAIL:   if (tick) state_nxt = STORE;
      STORE:   state_nxt = start ? LEAD : HOLD;
      HOLD:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    take      = 1'b0;
    rx_store  = 1'b0;
    xfer_done = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  take = start;
      STORE: begin
        take      = start;
        rx_store  = 1'b1;
        xfer_done = 1'b1;
      end
      default: ;
    endcase
    tx_load  = take;
    sck_load = take || (state == STORE);
    sck_idle = (state == IDLE) || take;
    sck_tgl  = (state == SHIFT) && tick;
    div_sel  = take ? clk_div : div_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
    end else if (take) begin
      ss_n     <= 1'b0;
      cpha_q   <= cpha;
      div_q    <= clk_div;
      edge_cnt <= '0;
      // CPHA=0 presents the MSB before the first edge, so pre-shift it out.
      if (cpha) begin
        tx_sr <= tx_data;
      end else begin
        tx_sr <= tx_data << 1;
        mosi  <= tx_data[DATA_WIDTH-1];
      end
    end else begin
      if (state == SHIFT && tick) begin
        edge_cnt <= edge_cnt + 1'b1;
        if (sample_now) begin
          rx_sr <= {rx_sr[DATA_WIDTH-2:0], sample_bit};
        end else begin
          mosi  <= tx_sr[DATA_WIDTH-1];
          tx_sr <= tx_sr << 1;
        end
      end
      if (state == TRAIL && tick) rx_data <= rx_sr;
      if (state == STORE) ss_n <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: FIFO model, SPI slave model, event counters.
module tb_spi_xfer_ctrl;
  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0] clk_div = 8'd1;
  logic [7:0] tx_data, rx_data;
  logic       tx_empty, tx_load, rx_full = 1'b0, rx_store;
  logic       sck, mosi, miso, ss_n, busy, xfer_done, loopback = 1'b0;

  int total = 0, bad = 0;

  spi_xfer_ctrl #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cpol      (cpol),
    .cpha      (cpha),
    .clk_div   (clk_div),
    .tx_data   (tx_data),
    .tx_empty  (tx_empty),
    .tx_load   (tx_load),
    .rx_full   (rx_full),
    .rx_store  (rx_store),
    .rx_data   (rx_data),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
`ifdef SPI_XFER_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .ss_n      (ss_n),
    .busy      (busy),
    .xfer_done (xfer_done)
  );

  always #5 clk = ~clk;

  // TX FIFO model
  logic [7:0] tx_mem [0:63];
  int tx_wr = 0, tx_rd = 0;
  assign tx_empty = (tx_rd == tx_wr);
  assign tx_data  = tx_mem[tx_rd[5:0]];
  always @(posedge clk) if (tx_load) tx_rd <= tx_rd + 1;

  // Event counters, sampled just before the active edge
  int n_load = 0, n_store = 0, n_done = 0, n_coinc = 0, ss_low = 0, ss_rise = 0;
  logic ss_prev = 1'b1;
  logic [7:0] rx_hist [0:63];
  always @(negedge clk) begin
    if (tx_load) n_load++;
    if (xfer_done) n_done++;
    if (rx_store) begin
      rx_hist[n_store[5:0]] = rx_data;
      n_store++;
      if (tx_load) n_coinc++;
    end
    if (!ss_n) ss_low++;
    if (ss_n && !ss_prev) ss_rise++;
    ss_prev = ss_n;
  end

  // SPI slave model: counts sck edges within a 16-edge frame
  int         slv_e = 0, slv_idx;
  logic       sck_q = 1'b0, slv_en = 1'b0;
  logic [7:0] slv_word = 8'h00, slv_rx = 8'h00, slv_sh;
  always @(negedge clk) begin
    if (ss_n) slv_e <= 0;
    else if (sck != sck_q) begin
      slv_e <= (slv_e == 15) ? 0 : slv_e + 1;
      if (slv_e[0] == cpha) slv_rx <= {slv_rx[6:0], mosi};
    end
    sck_q <= sck;
  end
  always_comb begin
    slv_idx = cpha ? ((slv_e == 0) ? 0 : (slv_e - 1) >> 1) : (slv_e >> 1);
    slv_sh  = slv_word << slv_idx;
    miso    = slv_en ? slv_sh[7] : mosi;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rxh(input int i);
    return 32'(rx_hist[i[5:0]]);
  endfunction

  task automatic push(input logic [7:0] v);
    tx_mem[tx_wr[5:0]] = v;
    tx_wr++;
  endtask

  task automatic wait_store(input int tgt);
    int c = 0;
    while (n_store < tgt && c < 2000) begin @(negedge clk); c++; end
    #1 chk("store_wait", 32'(c < 2000), 32'd1);
  endtask

  task automatic wait_load(input int tgt);
    int c = 0;
    while (n_load < tgt && c < 2000) begin @(negedge clk); c++; end
    #1 chk("load_wait", 32'(c < 2000), 32'd1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 2000) begin @(negedge clk); c++; end
    #1 chk("idle_wait", 32'(c < 2000), 32'd1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int s0, l0, ld0, d0, c0, r0;

  task automatic snap();
    s0 = n_store; l0 = ss_low; ld0 = n_load; d0 = n_done; c0 = n_coinc; r0 = ss_rise;
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_tx_load", 32'(tx_load), 32'd0);
    chk("rst_rx_store", 32'(rx_store), 32'd0);
    chk("rst_done", 32'(xfer_done), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step(); rst = 1'b0;

    // mode 0, external mosi->miso loop
    step(); snap(); push(8'hA5); enable = 1'b1;
    wait_store(s0 + 1); wait_idle();
    chk("m0_rx", rxh(s0), 32'hA5);
    chk("m0_slave_rx", 32'(slv_rx), 32'hA5);
    chk("m0_ss_low", 32'(ss_low - l0), 32'd37);
    chk("m0_loads", 32'(n_load - ld0), 32'd1);
    chk("m0_stores", 32'(n_store - s0), 32'd1);
    chk("m0_done", 32'(n_done - d0), 32'd1);
    chk("m0_sck_idle", 32'(sck), 32'd0);

    // modes 1..3 against the slave model
    for (int m = 1; m < 4; m++) begin
      step(); cpol = m[1]; cpha = m[0]; slv_en = 1'b1; slv_word = 8'hC3;
      repeat (2) step();
      chk($sformatf("m%0d_pre_idle", m), 32'(sck), 32'(m[1]));
      snap(); push(8'h3C);
      wait_store(s0 + 1); wait_idle();
      chk($sformatf("m%0d_rx", m), rxh(s0), 32'hC3);
      chk($sformatf("m%0d_slave_rx", m), 32'(slv_rx), 32'h3C);
      chk($sformatf("m%0d_sck_idle", m), 32'(sck), 32'(m[1]));
    end

    // chained frames
    step(); enable = 1'b0; cpol = 1'b0; cpha = 1'b0; slv_en = 1'b0;
    repeat (2) step();
    snap(); push(8'h11); push(8'h22); push(8'h33); enable = 1'b1;
    wait_store(s0 + 3); wait_idle();
    chk("ch_stores", 32'(n_store - s0), 32'd3);
    chk("ch_done", 32'(n_done - d0), 32'd3);
    chk("ch_coinc", 32'(n_coinc - c0), 32'd2);
    chk("ch_ss_rise", 32'(ss_rise - r0), 32'd1);
    chk("ch_ss_low", 32'(ss_low - l0), 32'd111);
    chk("ch_rx0", rxh(s0), 32'h11);
    chk("ch_rx1", rxh(s0 + 1), 32'h22);
    chk("ch_rx2", rxh(s0 + 2), 32'h33);

    // RX backpressure
    step(); enable = 1'b0; rx_full = 1'b1;
    snap(); push(8'h5A); enable = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_loads", 32'(n_load - ld0), 32'd0);
    step(); rx_full = 1'b0;
    @(negedge clk); #1;
    chk("bp_tx_load", 32'(tx_load), 32'd1);
    @(negedge clk); #1;
    chk("bp_busy_next", 32'(busy), 32'd1);
    wait_store(s0 + 1); wait_idle();
    chk("bp_rx", rxh(s0), 32'h5A);

`ifdef SPI_XFER_LOOPBACK_EN
    // internal loopback ignores the miso pin
    step(); slv_en = 1'b1; slv_word = 8'h00; loopback = 1'b1;
    snap(); push(8'h5A);
    wait_store(s0 + 1); wait_idle();
    chk("lb_rx", rxh(s0), 32'h5A);
    step(); loopback = 1'b0; slv_en = 1'b0;
`endif

    // enable dropped mid-frame: frame completes, no new frame starts
    step(); enable = 1'b0;
    snap(); push(8'h77); push(8'h88); enable = 1'b1;
    wait_load(ld0 + 1);
    step(); enable = 1'b0;
    wait_store(s0 + 1); wait_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("en_stores", 32'(n_store - s0), 32'd1);
    chk("en_loads", 32'(n_load - ld0), 32'd1);
    chk("en_rx", rxh(s0), 32'h77);
    chk("en_busy", 32'(busy), 32'd0);

    // async reset mid-SHIFT
    step(); snap(); enable = 1'b1;
    wait_load(ld0 + 1);
    repeat (10) @(negedge clk);
    step(); rst = 1'b1; enable = 1'b0;
    #1;
    chk("ar_ss_n", 32'(ss_n), 32'd1);
    chk("ar_sck", 32'(sck), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("ar_no_store", 32'(n_store - s0), 32'd0);
    step(); rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
